// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button synchronizers, IDLE/RUN/PAUSE FSM, tick prescaler and 00..99 BCD count.
// Optional lap/freeze display feature is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
   parameter int unsigned TICK_DIV = 5000000,
   parameter int unsigned TICK_W   = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_ss,
   input  logic       btn_clr,
`ifdef STOPWATCH_LAP_EN
   input  logic       btn_lap,
   output logic       lap_o,
`endif
   output logic [3:0] disp_ones,
   output logic [3:0] disp_tens,
   output logic       run_o,
   output logic       tick_o,
   output logic       wrap_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 32'd1);
   localparam logic [TICK_W-1:0] PRESC_ONE = TICK_W'(32'd1);

   // Returns {wrap, tens, ones} of the count advanced by one.
   function automatic logic [8:0] bcd_inc(input logic [3:0] ones, input logic [3:0] tens);
      logic [8:0] res;
      if (ones < 4'd9) begin
         res = {1'b0, tens, ones + 4'd1};
      end else if (tens < 4'd9) begin
         res = {1'b0, tens + 4'd1, 4'd0};
      end else begin
         res = {1'b1, 4'd0, 4'd0};
      end
      return res;
   endfunction

   state_t            state_r;
   state_t            state_nxt_s;
   logic [TICK_W-1:0] presc_r;
   logic [TICK_W-1:0] presc_nxt_s;
   logic [3:0]        ones_r;
   logic [3:0]        tens_r;
   logic [3:0]        ones_nxt_s;
   logic [3:0]        tens_nxt_s;
   logic [8:0]        inc_s;
   logic              tick_s;
   logic              tick_nxt_s;
   logic              wrap_nxt_s;
   logic              run_r;
   logic              tick_r;
   logic              wrap_r;
   logic [2:0]        ss_sync_r;
   logic [2:0]        clr_sync_r;
   logic              ss_edge_s;
   logic              clr_edge_s;

   // Button synchronizers plus one delayed copy for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_sync_r  <= 3'b000;
         clr_sync_r <= 3'b000;
      end else begin
         ss_sync_r  <= {ss_sync_r[1:0], btn_ss};
         clr_sync_r <= {clr_sync_r[1:0], btn_clr};
      end
   end

   assign ss_edge_s  = ss_sync_r[1] & ~ss_sync_r[2];
   assign clr_edge_s = clr_sync_r[1] & ~clr_sync_r[2];

   assign tick_s = (state_r == ST_RUN) && (presc_r == TICK_LAST);
   assign inc_s  = bcd_inc(ones_r, tens_r);

   // Next-state, prescaler and count update; clear beats start/stop and discards a tick.
   always_comb begin
      state_nxt_s = state_r;
      presc_nxt_s = presc_r;
      ones_nxt_s  = ones_r;
      tens_nxt_s  = tens_r;
      tick_nxt_s  = 1'b0;
      wrap_nxt_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (ss_edge_s && !clr_edge_s) begin
               state_nxt_s = ST_RUN;
               presc_nxt_s = '0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (clr_edge_s) begin
               state_nxt_s = ST_IDLE;
               presc_nxt_s = '0;
               ones_nxt_s  = 4'd0;
               tens_nxt_s  = 4'd0;
            end else begin
               // A tick coinciding with stop is still counted; otherwise stop freezes the prescaler.
               if (tick_s) begin
                  presc_nxt_s = '0;
                  ones_nxt_s  = inc_s[3:0];
                  tens_nxt_s  = inc_s[7:4];
                  tick_nxt_s  = 1'b1;
                  wrap_nxt_s  = inc_s[8];
               end else if (ss_edge_s) begin
                  presc_nxt_s = presc_r;
               end else begin
                  presc_nxt_s = presc_r + PRESC_ONE;
               end
               if (ss_edge_s) begin
                  state_nxt_s = ST_PAUSE;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
         end
         ST_PAUSE: begin
            if (clr_edge_s) begin
               state_nxt_s = ST_IDLE;
               presc_nxt_s = '0;
               ones_nxt_s  = 4'd0;
               tens_nxt_s  = 4'd0;
            end else if (ss_edge_s) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_PAUSE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            presc_nxt_s = '0;
            ones_nxt_s  = 4'd0;
            tens_nxt_s  = 4'd0;
         end
      endcase
   end

   // FSM, prescaler, live count and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         presc_r <= '0;
         ones_r  <= 4'd0;
         tens_r  <= 4'd0;
         run_r   <= 1'b0;
         tick_r  <= 1'b0;
         wrap_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         presc_r <= presc_nxt_s;
         ones_r  <= ones_nxt_s;
         tens_r  <= tens_nxt_s;
         run_r   <= (state_nxt_s == ST_RUN);
         tick_r  <= tick_nxt_s;
         wrap_r  <= wrap_nxt_s;
      end
   end

   assign run_o  = run_r;
   assign tick_o = tick_r;
   assign wrap_o = wrap_r;

`ifdef STOPWATCH_LAP_EN
   logic [2:0] lap_sync_r;
   logic       lap_edge_s;
   logic       freeze_r;
   logic       freeze_nxt_s;
   logic [3:0] disp_ones_r;
   logic [3:0] disp_tens_r;

   // Lap button synchronizer and edge-detect history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lap_sync_r <= 3'b000;
      end else begin
         lap_sync_r <= {lap_sync_r[1:0], btn_lap};
      end
   end

   assign lap_edge_s = lap_sync_r[1] & ~lap_sync_r[2];

   // Freeze toggles on lap in RUN/PAUSE and is dropped whenever the FSM heads to IDLE.
   always_comb begin
      freeze_nxt_s = freeze_r;
      if (state_nxt_s == ST_IDLE) begin
         freeze_nxt_s = 1'b0;
      end else if (lap_edge_s && (state_r != ST_IDLE)) begin
         freeze_nxt_s = ~freeze_r;
      end else begin
         freeze_nxt_s = freeze_r;
      end
   end

   // Display register: holds while frozen, otherwise tracks the live count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         freeze_r    <= 1'b0;
         disp_ones_r <= 4'd0;
         disp_tens_r <= 4'd0;
      end else begin
         freeze_r <= freeze_nxt_s;
         if (!freeze_nxt_s) begin
            disp_ones_r <= ones_nxt_s;
            disp_tens_r <= tens_nxt_s;
         end else begin
            disp_ones_r <= disp_ones_r;
            disp_tens_r <= disp_tens_r;
         end
      end
   end

   assign disp_ones = disp_ones_r;
   assign disp_tens = disp_tens_r;
   assign lap_o     = freeze_r;
`else
   assign disp_ones = ones_r;
   assign disp_tens = tens_r;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Table-driven bench for stopwatch_ctrl with TICK_DIV=4; expectations flow through a scoreboard queue.
module tb_stopwatch_ctrl;

   logic       clk;
   logic       rst_n;
   logic       btn_ss;
   logic       btn_clr;
   logic       btn_lap;
   logic [3:0] disp_ones;
   logic [3:0] disp_tens;
   logic       run_o;
   logic       tick_o;
   logic       wrap_o;
`ifdef STOPWATCH_LAP_EN
   logic       lap_o;
`endif

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
      logic       run;
      logic       tick;
      logic       wrap;
      logic       lap;
   } exp_t;

   typedef struct packed {
      logic  ss;
      logic  clr;
      logic  lap;
      int    ncyc;
      exp_t  exp;
   } vec_t;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb_q[$];
   vec_t tbl[$];

   stopwatch_ctrl #(.TICK_DIV(4), .TICK_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_ss    (btn_ss),
      .btn_clr   (btn_clr),
`ifdef STOPWATCH_LAP_EN
      .btn_lap   (btn_lap),
      .lap_o     (lap_o),
`endif
      .disp_ones (disp_ones),
      .disp_tens (disp_tens),
      .run_o     (run_o),
      .tick_o    (tick_o),
      .wrap_o    (wrap_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void add(input logic ss, input logic clr, input logic lap, input int n,
                               input int tens, input int ones, input logic run,
                               input logic tick, input logic wrap, input logic lapx);
      vec_t v;
      v.ss   = ss;
      v.clr  = clr;
      v.lap  = lap;
      v.ncyc = n;
      v.exp  = '{tens: 4'(tens), ones: 4'(ones), run: run, tick: tick, wrap: wrap, lap: lapx};
      tbl.push_back(v);
   endfunction

   task automatic check_out(input string name);
      exp_t        e;
      logic        lapv;
      logic [11:0] got;
      logic [11:0] want;
`ifdef STOPWATCH_LAP_EN
      lapv = lap_o;
`else
      lapv = 1'b0;
`endif
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e    = sb_q.pop_front();
         got  = {disp_tens, disp_ones, run_o, tick_o, wrap_o, lapv};
         want = e;
         if (got !== want) begin
            failures++;
            $display("FAIL %s: got tens=%0d ones=%0d run=%b tick=%b wrap=%b lap=%b, want tens=%0d ones=%0d run=%b tick=%b wrap=%b lap=%b",
                     name, disp_tens, disp_ones, run_o, tick_o, wrap_o, lapv,
                     e.tens, e.ones, e.run, e.tick, e.wrap, e.lap);
         end
      end
   endtask

   // Press buttons for one cycle at a negedge, wait ncyc negedges in total, then compare.
   task automatic apply(input vec_t v, input string name);
      sb_q.push_back(v.exp);
      btn_ss  = v.ss;
      btn_clr = v.clr;
      btn_lap = v.lap;
      @(negedge clk);
      btn_ss  = 1'b0;
      btn_clr = 1'b0;
      btn_lap = 1'b0;
      repeat (v.ncyc - 1) @(negedge clk);
      check_out(name);
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("%s%0d", tag, i));
      end
      tbl.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b0;
      btn_ss  = 1'b0;
      btn_clr = 1'b0;
      btn_lap = 1'b0;
      repeat (2) @(negedge clk);
      sb_q.push_back('0);
      check_out("reset_state");
      rst_n = 1'b1;

      // start, ten ticks, pause at prescaler 2, resume, clr+ss at 42, then run through wrap to 37
      add(0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0,   2, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0,   1, 0, 0, 1, 0, 0, 0);
      add(0, 0, 0,   4, 0, 1, 1, 1, 0, 0);
      add(0, 0, 0,   1, 0, 1, 1, 0, 0, 0);
      add(0, 0, 0,  35, 1, 0, 1, 1, 0, 0);
      add(0, 0, 0,   1, 1, 0, 1, 0, 0, 0);
      add(0, 0, 0,   3, 1, 1, 1, 1, 0, 0);
      add(1, 0, 0,   3, 1, 1, 0, 0, 0, 0);
      add(0, 0, 0,  50, 1, 1, 0, 0, 0, 0);
      add(1, 0, 0,   3, 1, 1, 1, 0, 0, 0);
      add(0, 0, 0,   1, 1, 1, 1, 0, 0, 0);
      add(0, 0, 0,   1, 1, 2, 1, 1, 0, 0);
      add(0, 0, 0, 120, 4, 2, 1, 1, 0, 0);
      add(0, 0, 0,   1, 4, 2, 1, 0, 0, 0);
      add(1, 1, 0,   3, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0,   8, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0,   3, 0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 396, 9, 9, 1, 1, 0, 0);
      add(0, 0, 0,   4, 0, 0, 1, 1, 1, 0);
      add(0, 0, 0,   1, 0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 147, 3, 7, 1, 1, 0, 0);
      add(0, 0, 0,   1, 3, 7, 1, 0, 0, 0);
      run_table("main");

      // asynchronous reset in the middle of a cycle while running at 37
      #2;
      rst_n = 1'b0;
      #1;
      sb_q.push_back('0);
      check_out("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      sb_q.push_back('0);
      check_out("idle_after_reset");

`ifdef STOPWATCH_LAP_EN
      do_reset();
      add(1, 0, 0,  3, 0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 19, 0, 4, 1, 0, 0, 0);
      add(0, 0, 1,  3, 0, 5, 1, 0, 0, 1);
      add(0, 0, 0, 10, 0, 5, 1, 1, 0, 1);
      add(0, 0, 1,  3, 0, 8, 1, 0, 0, 0);
      add(0, 0, 0,  1, 0, 9, 1, 1, 0, 0);
      add(0, 1, 0,  3, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1,  5, 0, 0, 0, 0, 0, 0);
      run_table("lap");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
